// File: rtl/id_ex_reg.sv
// ============================================================================
// Module   : id_ex_reg
// Brief    : ID/EX pipeline register with hold, bubble insertion, in-place
//            operand refresh while held and D->E Tnew conversion.
//            Optional bubble counter enabled by macro IDEX_BUBBLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_ext,
    input  logic [4:0]  D_wa,
    input  logic [1:0]  D_tnew,
    input  logic        fwd_rs_en,
    input  logic        fwd_rt_en,
    input  logic [31:0] fwd_rs_data,
    input  logic [31:0] fwd_rt_data,
    output logic [31:0] E_pc,
    output logic [31:0] E_instr,
    output logic [31:0] E_rs_data,
    output logic [31:0] E_rt_data,
    output logic [31:0] E_ext,
    output logic [4:0]  E_wa,
    output logic [1:0]  E_tnew,
    output logic        E_valid,
    output logic [31:0] bubble_cnt
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_ext;
    logic [4:0]  r_wa;
    logic [1:0]  r_tnew;
    logic        r_valid;
    logic [1:0]  w_tnew_dec;

    // One stage of progress consumed between D and E; a ready result stays ready.
    assign w_tnew_dec = (D_tnew == 2'd0) ? 2'd0 : (D_tnew - 2'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= 32'h0;
            r_instr   <= 32'h0;
            r_rs_data <= 32'h0;
            r_rt_data <= 32'h0;
            r_ext     <= 32'h0;
            r_wa      <= 5'd0;
            r_tnew    <= 2'd0;
            r_valid   <= 1'b0;
        end else if (hold) begin
            // Held instruction keeps waiting on operands that may still be produced.
            if (r_valid) begin
                if (fwd_rs_en) r_rs_data <= fwd_rs_data;
                if (fwd_rt_en) r_rt_data <= fwd_rt_data;
            end
        end else if (flush) begin
            r_pc      <= D_pc;
            r_instr   <= 32'h0;
            r_rs_data <= 32'h0;
            r_rt_data <= 32'h0;
            r_ext     <= 32'h0;
            r_wa      <= 5'd0;
            r_tnew    <= 2'd0;
            r_valid   <= 1'b0;
        end else begin
            r_pc      <= D_pc;
            r_instr   <= D_instr;
            r_rs_data <= D_rs_data;
            r_rt_data <= D_rt_data;
            r_ext     <= D_ext;
            r_wa      <= D_wa;
            r_tnew    <= w_tnew_dec;
            r_valid   <= 1'b1;
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubble_cnt <= 32'h0;
        end else if (!hold && flush && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    assign bubble_cnt = 32'h0;
`endif

    assign E_pc      = r_pc;
    assign E_instr   = r_instr;
    assign E_rs_data = r_rs_data;
    assign E_rt_data = r_rt_data;
    assign E_ext     = r_ext;
    assign E_wa      = r_wa;
    assign E_tnew    = r_tnew;
    assign E_valid   = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// ============================================================================
// Module   : tb_id_ex_reg
// Brief    : Self-checking bench for id_ex_reg: directed vector table,
//            asynchronous-reset sequence and randomized reference-model run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold, flush;
    logic [31:0] D_pc, D_instr, D_rs_data, D_rt_data, D_ext;
    logic [4:0]  D_wa;
    logic [1:0]  D_tnew;
    logic        fwd_rs_en, fwd_rt_en;
    logic [31:0] fwd_rs_data, fwd_rt_data;
    logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_ext;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic        E_valid;
    logic [31:0] bubble_cnt;

    int tests = 0;
    int fails = 0;

    id_ex_reg dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .D_pc(D_pc), .D_instr(D_instr), .D_rs_data(D_rs_data),
        .D_rt_data(D_rt_data), .D_ext(D_ext), .D_wa(D_wa), .D_tnew(D_tnew),
        .fwd_rs_en(fwd_rs_en), .fwd_rt_en(fwd_rt_en),
        .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
        .E_pc(E_pc), .E_instr(E_instr), .E_rs_data(E_rs_data),
        .E_rt_data(E_rt_data), .E_ext(E_ext), .E_wa(E_wa), .E_tnew(E_tnew),
        .E_valid(E_valid), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the E-stage contents as the pipeline rules describe them.
    logic [31:0] m_pc, m_instr, m_rs, m_rt, m_ext;
    logic [4:0]  m_wa;
    int          m_tnew;
    logic        m_valid;
    longint unsigned m_bub;

    function automatic void model_reset();
        m_pc = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_ext = 0;
        m_wa = 0; m_tnew = 0; m_valid = 0; m_bub = 0;
    endfunction

    function automatic void model_edge();
        if (hold) begin
            if (m_valid && fwd_rs_en) m_rs = fwd_rs_data;
            if (m_valid && fwd_rt_en) m_rt = fwd_rt_data;
        end else if (flush) begin
            m_pc = D_pc; m_instr = 0; m_rs = 0; m_rt = 0; m_ext = 0;
            m_wa = 0; m_tnew = 0; m_valid = 0;
            if (m_bub < 64'hFFFF_FFFF) m_bub = m_bub + 1;
        end else begin
            m_pc = D_pc; m_instr = D_instr; m_rs = D_rs_data; m_rt = D_rt_data;
            m_ext = D_ext; m_wa = D_wa; m_valid = 1;
            m_tnew = (int'(D_tnew) > 0) ? int'(D_tnew) - 1 : 0;
        end
    endfunction

    function automatic logic [31:0] exp_bub();
`ifdef IDEX_BUBBLE_CNT_EN
        return m_bub[31:0];
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    E_pc,              m_pc);
        chk({tag, ".instr"}, E_instr,           m_instr);
        chk({tag, ".rs"},    E_rs_data,         m_rs);
        chk({tag, ".rt"},    E_rt_data,         m_rt);
        chk({tag, ".ext"},   E_ext,             m_ext);
        chk({tag, ".wa"},    {27'h0, E_wa},     {27'h0, m_wa});
        chk({tag, ".tnew"},  {30'h0, E_tnew},   32'(m_tnew));
        chk({tag, ".valid"}, {31'h0, E_valid},  {31'h0, m_valid});
        chk({tag, ".bub"},   bubble_cnt,        exp_bub());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        logic        hold, flush;
        logic [31:0] pc, instr, rs, rt, ext;
        logic [4:0]  wa;
        logic [1:0]  tnew;
        logic        frs_en, frt_en;
        logic [31:0] frs, frt;
        logic [31:0] e_pc, e_instr, e_rs, e_rt, e_ext;
        logic [4:0]  e_wa;
        logic [1:0]  e_tnew;
        logic        e_valid;
    } vec_t;

    vec_t vecs[12];

    task automatic apply(input vec_t v);
        hold = v.hold; flush = v.flush;
        D_pc = v.pc; D_instr = v.instr; D_rs_data = v.rs; D_rt_data = v.rt;
        D_ext = v.ext; D_wa = v.wa; D_tnew = v.tnew;
        fwd_rs_en = v.frs_en; fwd_rt_en = v.frt_en;
        fwd_rs_data = v.frs; fwd_rt_data = v.frt;
    endtask

    initial begin
        //          hold flush pc           instr        rs           rt           ext          wa  tn frs frt frs_data     frt_data      | e_pc        e_instr      e_rs         e_rt         e_ext        e_wa tn v
        vecs[0]  = '{0, 0, 32'h00003000, 32'h3C011234, 32'h00000011, 32'h00000022, 32'hFFFF8000, 5'd8, 2'd2, 0, 0, 32'h0, 32'h0,
                     32'h00003000, 32'h3C011234, 32'h00000011, 32'h00000022, 32'hFFFF8000, 5'd8, 2'd1, 1};
        vecs[1]  = '{0, 1, 32'h00003004, 32'h11111111, 32'h2, 32'h3, 32'h4, 5'd9, 2'd3, 0, 0, 32'h0, 32'h0,
                     32'h00003004, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 0};
        vecs[2]  = '{0, 0, 32'h00003008, 32'h3C011234, 32'h0000000A, 32'h0000000B, 32'h00001234, 5'd1, 2'd3, 0, 0, 32'h0, 32'h0,
                     32'h00003008, 32'h3C011234, 32'h0000000A, 32'h0000000B, 32'h00001234, 5'd1, 2'd2, 1};
        vecs[3]  = '{1, 1, 32'h00009999, 32'h99999999, 32'h9, 32'h9, 32'h9, 5'd31, 2'd1, 0, 0, 32'h0, 32'h0,
                     32'h00003008, 32'h3C011234, 32'h0000000A, 32'h0000000B, 32'h00001234, 5'd1, 2'd2, 1};
        vecs[4]  = vecs[3];
        vecs[5]  = vecs[3];
        vecs[6]  = '{1, 0, 32'h00009999, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 0, 1, 32'h12345678, 32'hDEADBEEF,
                     32'h00003008, 32'h3C011234, 32'h0000000A, 32'hDEADBEEF, 32'h00001234, 5'd1, 2'd2, 1};
        vecs[7]  = '{1, 0, 32'h00009999, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1, 0, 32'h0000CAFE, 32'h55555555,
                     32'h00003008, 32'h3C011234, 32'h0000CAFE, 32'hDEADBEEF, 32'h00001234, 5'd1, 2'd2, 1};
        vecs[8]  = '{0, 0, 32'h0000300C, 32'h00000000, 32'h1, 32'h2, 32'h3, 5'd0, 2'd0, 0, 0, 32'h0, 32'h0,
                     32'h0000300C, 32'h00000000, 32'h1, 32'h2, 32'h3, 5'd0, 2'd0, 1};
        vecs[9]  = '{0, 1, 32'h00003010, 32'h7, 32'h7, 32'h7, 32'h7, 5'd7, 2'd3, 0, 0, 32'h0, 32'h0,
                     32'h00003010, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 0};
        vecs[10] = '{1, 0, 32'h00003014, 32'h7, 32'h7, 32'h7, 32'h7, 5'd7, 2'd3, 1, 1, 32'h44444444, 32'hDEADBEEF,
                     32'h00003010, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 0};
        vecs[11] = '{0, 0, 32'h00003018, 32'hAABBCCDD, 32'h000000AA, 32'h000000BB, 32'h0000FFFF, 5'd3, 2'd1, 1, 1, 32'h44444444, 32'h66666666,
                     32'h00003018, 32'hAABBCCDD, 32'h000000AA, 32'h000000BB, 32'h0000FFFF, 5'd3, 2'd0, 1};

        reset = 1'b1;
        apply('{default: '0});
        #2 reset = 1'b0;
        model_reset();
        #1 chk_model("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            tick();
            chk($sformatf("v%0d.pc", i),    E_pc,             vecs[i].e_pc);
            chk($sformatf("v%0d.instr", i), E_instr,          vecs[i].e_instr);
            chk($sformatf("v%0d.rs", i),    E_rs_data,        vecs[i].e_rs);
            chk($sformatf("v%0d.rt", i),    E_rt_data,        vecs[i].e_rt);
            chk($sformatf("v%0d.ext", i),   E_ext,            vecs[i].e_ext);
            chk($sformatf("v%0d.wa", i),    {27'h0, E_wa},    {27'h0, vecs[i].e_wa});
            chk($sformatf("v%0d.tnew", i),  {30'h0, E_tnew},  {30'h0, vecs[i].e_tnew});
            chk($sformatf("v%0d.valid", i), {31'h0, E_valid}, {31'h0, vecs[i].e_valid});
            chk_model($sformatf("v%0d.model", i));
        end

        // Asynchronous reset in the middle of a hold, then a normal load.
        apply(vecs[0]);
        tick();
        hold = 1'b1; flush = 1'b1;
        tick();
        #2 reset = 1'b0;
        model_reset();
        #1 chk_model("async_rst");
        @(negedge clk);
        reset = 1'b1;
        apply(vecs[2]);
        tick();
        chk("post_rst.pc",   E_pc,             32'h00003008);
        chk("post_rst.tnew", {30'h0, E_tnew},  32'd2);
        chk("post_rst.valid",{31'h0, E_valid}, 32'd1);
        chk_model("post_rst");

        // Randomized run against the reference model.
        for (int n = 0; n < 400; n++) begin
            hold        = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 3) == 0);
            D_pc        = $urandom; D_instr = $urandom;
            D_rs_data   = $urandom; D_rt_data = $urandom; D_ext = $urandom;
            D_wa        = 5'($urandom); D_tnew = 2'($urandom);
            fwd_rs_en   = 1'($urandom); fwd_rt_en = 1'($urandom);
            fwd_rs_data = $urandom; fwd_rt_data = $urandom;
            tick();
            chk_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the five-stage MIPS core. It sits directly downstream of the decode-stage immediate extender and register file, and latches the 32-bit extended immediate together with the rest of the D-stage bundle for the E stage. It implements E-stage hold, bubble insertion and in-place operand refresh while held, and converts the D-stage Tnew into E-stage Tnew.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `hold`  in  1  freeze E stage (E-stage multi-cycle unit busy).
- `flush`  in  1  insert a bubble into E (D-stage hazard stall).
- `D_pc`  in  32  PC of the D instruction.
- `D_instr`  in  32  D instruction word.
- `D_rs_data`  in  32  forwarded rs value.
- `D_rt_data`  in  32  forwarded rt value.
- `D_ext`  in  32  extended immediate from the extender.
- `D_wa`  in  5  destination register number (0 = none).
- `D_tnew`  in  2  cycles until the result is available, measured at D.
- `fwd_rs_en`, `fwd_rt_en`  in  1  refresh enables, used only while held.
- `fwd_rs_data`, `fwd_rt_data`  in  32  refresh values.
- `E_pc`, `E_instr`, `E_rs_data`, `E_rt_data`, `E_ext`  out  32  latched fields.
- `E_wa`  out  5  latched destination.
- `E_tnew`  out  2  E-stage Tnew.
- `E_valid`  out  1  1 = real instruction, 0 = bubble.
- `bubble_cnt`  out  32  bubble counter (see Configuration).

## Operation
- Per-edge priority: reset > hold > flush > load.
- **Load** (hold=0, flush=0):
  - All E fields take their D values.
  - `E_valid`=1.
  - `E_tnew` = `D_tnew`−1, saturating at 0.
- **Flush** (hold=0, flush=1):
  - `E_instr`, `E_rs_data`, `E_rt_data`, `E_ext`, `E_wa`, `E_tnew` become 0.
  - `E_valid`=0.
  - `E_pc` takes `D_pc`, preserved for later exception use.
- **Hold** (hold=1):
  - All fields keep their values, with one exception: when `E_valid`=1, `E_rs_data` takes `fwd_rs_data` if `fwd_rs_en`=1, and `E_rt_data` takes `fwd_rt_data` if `fwd_rt_en`=1.
  - The refresh enables have no effect when `E_valid`=0 or hold=0.
- Hold and flush together: hold wins and the held instruction is not killed. D is also stalled, so no instruction is lost.
- `E_wa`=0 with `E_valid`=1 is legal and means "no write". The register does not force it.
- No combinational path from any input to any output.

## Timing
- Reset (asynchronous, `reset`=0): all outputs 0 immediately, `E_valid`=0, `bubble_cnt`=0. Release takes effect at the first rising edge with `reset`=1.
- Latency: one cycle from a D-bundle load to E outputs.
- Hold of N cycles keeps E outputs constant for N edges, except for refreshed operands. Each refresh is visible one cycle after the edge on which it was sampled.
- Reset asserted mid-hold or mid-flush clears everything; the next load after reset release is a normal load.
- `D_tnew`=0 → `E_tnew`=0 (no wrap to 3). `D_tnew`=3 → `E_tnew`=2.

## Configuration
- Macro `IDEX_BUBBLE_CNT_EN`.
- Defined:
  - `bubble_cnt` increments by 1 on every edge where flush is accepted (hold=0, flush=1).
  - It saturates at 32'hFFFFFFFF and clears only on reset.
- Undefined: the counter logic is absent and `bubble_cnt` is tied to 32'h00000000. The port list is identical in both builds.

## Test plan
- Reset then load: pulse `reset`=0 → all outputs 0. Next edge with `D_pc`=32'h00003000, `D_ext`=32'hFFFF8000, `D_wa`=5'd8, `D_tnew`=2 → `E_pc`=32'h00003000, `E_ext`=32'hFFFF8000, `E_wa`=8, `E_tnew`=1, `E_valid`=1.
- Flush: `flush`=1, `D_pc`=32'h00003004 → `E_instr`=0, `E_wa`=0, `E_valid`=0, `E_pc`=32'h00003004. With `IDEX_BUBBLE_CNT_EN`, `bubble_cnt` goes 0→1.
- Hold beats flush: E holds instr 32'h3C011234; hold=1 and flush=1 for 3 edges → outputs unchanged, `E_valid`=1, `bubble_cnt` unchanged.
- Refresh during hold: hold=1, `fwd_rt_en`=1, `fwd_rt_data`=32'hDEADBEEF → `E_rt_data`=32'hDEADBEEF after that edge, `E_rs_data` unchanged. Same stimulus with `E_valid`=0 → no change.
- Tnew saturation: `D_tnew`=0 → `E_tnew`=0. `D_tnew`=3 → `E_tnew`=2.
- Asynchronous reset mid-hold: assert `reset`=0 between edges → outputs 0 before the next edge. After release, the first load behaves normally.
